// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the 5x5 convolution window generator.
package conv_window_gen_pkg;

    localparam int K    = 5;        // window size (rows and columns)
    localparam int DW   = 9;        // pixel width, signed two's complement
    localparam int COLW = K * DW;   // one packed window column
    localparam int NLB  = K - 1;    // number of stored previous lines

    // Counter width able to index 0..n-1 (never narrower than one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// One image line of pixel storage, addressed by column. The read port is
// combinational so the old pixel at a column is seen in the same cycle the
// new pixel is written there (read-before-write). Contents are not reset:
// every location is rewritten before it can reach a window.
module line_buf
    import conv_window_gen_pkg::*;
#(
    parameter int W     = DW,
    parameter int DEPTH = 28,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_r [DEPTH];

    // Old contents at the addressed column
    always_comb begin
        rd_data = mem_r[addr];
    end

    // Overwrite the addressed column on an accepted beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 5x5 window generator. Keeps the previous four
// lines in a cascade of line buffers, shifts a 5-column window on each
// accepted pixel, and announces windows lying fully inside the frame with a
// one-cycle x_valid pulse, then throttles the source for HOLD cycles while
// the engine reads the columns.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = conv_window_gen_pkg::DW,
    parameter int HOLD  = 5
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                pix_valid,
    input  logic [DW-1:0]                       pix_data,
    output logic                                pix_ready,
    output logic                                x_valid,
    output logic [conv_window_gen_pkg::K*DW-1:0] x_m_1,
    output logic [conv_window_gen_pkg::K*DW-1:0] x_m_2,
    output logic [conv_window_gen_pkg::K*DW-1:0] x_m_3,
    output logic [conv_window_gen_pkg::K*DW-1:0] x_m_4,
    output logic [conv_window_gen_pkg::K*DW-1:0] x_m_5
);

    import conv_window_gen_pkg::*;

    localparam int CW    = K * DW;
    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int HC_W  = cnt_w(HOLD + 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [HC_W-1:0]  hold_cnt_r;

    logic             accept_s;
    logic             emit_s;
    logic             col_last_s;
    logic             row_last_s;
    logic [DW-1:0]    lb_wr_s [NLB];
    logic [DW-1:0]    lb_rd_s [NLB];
    logic [CW-1:0]    new_col_s;

    // Handshake, emit gating and the line-buffer cascade wiring
    always_comb begin
        accept_s   = pix_valid && pix_ready;
        emit_s     = (row_r >= ROW_W'(K - 1)) && (col_r >= COL_W'(K - 1));
        col_last_s = (col_r == COL_W'(IMG_W - 1));
        row_last_s = (row_r == ROW_W'(IMG_H - 1));
        lb_wr_s[0] = pix_data;
        for (int i = 1; i < NLB; i++) begin
            lb_wr_s[i] = lb_rd_s[i-1];
        end
        // oldest line on top, incoming pixel at the bottom
        new_col_s = {lb_rd_s[3], lb_rd_s[2], lb_rd_s[1], lb_rd_s[0], pix_data};
    end

    // L0 holds line r-1, each later buffer one line older
    for (genvar g = 0; g < NLB; g++) begin : g_lb
        line_buf #(
            .W     (DW),
            .DEPTH (IMG_W),
            .AW    (COL_W)
        ) u_line_buf (
            .clk     (clk),
            .we      (accept_s),
            .addr    (col_r),
            .wr_data (lb_wr_s[g]),
            .rd_data (lb_rd_s[g])
        );
    end

    // Raster position of the next pixel, wrapping at line and frame ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Window shift register and the one-cycle new-window pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_valid <= 1'b0;
            x_m_1   <= '0;
            x_m_2   <= '0;
            x_m_3   <= '0;
            x_m_4   <= '0;
            x_m_5   <= '0;
        end else begin
            x_valid <= accept_s && emit_s;
            if (accept_s) begin
                x_m_1 <= x_m_2;
                x_m_2 <= x_m_3;
                x_m_3 <= x_m_4;
                x_m_4 <= x_m_5;
                x_m_5 <= new_col_s;
            end
        end
    end

    // Keep pix_ready low for HOLD cycles after each emitted window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_ready  <= 1'b1;
            hold_cnt_r <= '0;
        end else if (accept_s && emit_s) begin
            pix_ready  <= 1'b0;
            hold_cnt_r <= HC_W'(HOLD - 1);
        end else if (!pix_ready) begin
            if (hold_cnt_r == '0) begin
                pix_ready <= 1'b1;
            end else begin
                hold_cnt_r <= hold_cnt_r - HC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on an 8x8 image: the driver records
// every accepted pixel in an image array and queues the expected window
// whenever one is due; a negedge monitor pops and compares on x_valid and
// checks the throttle/stability window that follows.
module tb_conv_window_gen;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int HOLD = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_valid = 1'b0;
    logic [8:0]  pix_data = '0;
    logic        pix_ready;
    logic        x_valid;
    logic [44:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
    logic [224:0] cur_w;

    assign cur_w = {x_m_1, x_m_2, x_m_3, x_m_4, x_m_5};

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (9),
        .HOLD  (HOLD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .x_valid   (x_valid),
        .x_m_1     (x_m_1),
        .x_m_2     (x_m_2),
        .x_m_3     (x_m_3),
        .x_m_4     (x_m_4),
        .x_m_5     (x_m_5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [224:0] exp_q[$];
    logic [8:0]   img [H][W];
    int           mr = 0;
    int           mc = 0;
    int           acc36_cyc = 0;
    int           first_xv_cyc = -1;
    int           pulse_cnt = 0;
    logic [44:0]  cap1 [256];
    logic [44:0]  cap5 [256];
    int           hold_ph = 0;
    bit           hold_bad = 1'b0;
    logic [224:0] snap = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] pack5(input int a, input int b, input int c,
                                          input int d, input int e);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e)};
    endfunction

    // window whose bottom-right pixel is (r,c): columns c-4..c, rows r-4..r
    function automatic logic [224:0] model_window(input int r, input int c);
        logic [224:0] w;
        logic [44:0]  col;
        w = '0;
        for (int j = 0; j < 5; j++) begin
            col = {img[r-4][c-4+j], img[r-3][c-4+j], img[r-2][c-4+j],
                   img[r-1][c-4+j], img[r][c-4+j]};
            w = {w[179:0], col};
        end
        return w;
    endfunction

    task automatic model_accept(input logic [8:0] v);
        img[mr][mc] = v;
        if (mr >= 4 && mc >= 4) exp_q.push_back(model_window(mr, mc));
        if (mr == 4 && mc == 4) acc36_cyc = cyc + 1;
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic drive_pixel(input logic [8:0] v, input int gap_pct);
        int  tries;
        bit  done;
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            tries++;
            if (tries > 200) begin
                $display("FAIL drive_timeout: actual=pix_ready stuck required=accept within 200 cycles");
                $fatal(1);
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = v;
                if (pix_ready === 1'b1) begin
                    model_accept(v);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    // mode 0: base + r*8 + c; mode 1: random pixels with -1 at (4,4)
    task automatic run_frame(input int mode, input int base, input int gap, input bit chk37);
        logic [8:0] v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (chk37 && r == 4 && c == 4) chk("no_early_window", 256'(pulse_cnt), 256'(0));
                if (mode == 0) v = 9'(base + r * W + c);
                else if (r == 4 && c == 4) v = 9'h1FF;
                else v = 9'($urandom);
                drive_pixel(v, gap);
            end
        end
    endtask

    task automatic check_first_frame();
        chk("pulses_frame", 256'(pulse_cnt), 256'(16));
        chk("first_xv_latency", 256'(first_xv_cyc), 256'(acc36_cyc));
        chk("first_x_m_1", 256'(cap1[0]), 256'(pack5(0, 8, 16, 24, 32)));
        chk("first_x_m_5", 256'(cap5[0]), 256'(pack5(4, 12, 20, 28, 36)));
        chk("row5_x_m_1", 256'(cap1[4]), 256'(pack5(8, 16, 24, 32, 40)));
        chk("queue_drained", 256'(exp_q.size()), 256'(0));
    endtask

    // Scoreboard monitor: window compare on x_valid plus the hold window after it
    always @(negedge clk) begin
        if (!rstn) begin
            hold_ph = 0;
        end else begin
            if (hold_ph > 0) begin
                if (hold_ph <= HOLD - 1) begin
                    if (pix_ready !== 1'b0 || x_valid !== 1'b0 || cur_w !== snap) hold_bad = 1'b1;
                    hold_ph++;
                end else begin
                    if (pix_ready !== 1'b1) hold_bad = 1'b1;
                    chk("hold_throttle", 256'(hold_bad), 256'(0));
                    hold_ph = 0;
                end
            end
            if (x_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_x_valid", 256'(1), 256'(0));
                end else begin
                    chk("window", 256'(cur_w), 256'(exp_q.pop_front()));
                end
                if (first_xv_cyc < 0) first_xv_cyc = cyc;
                cap1[pulse_cnt[7:0]] = x_m_1;
                cap5[pulse_cnt[7:0]] = x_m_5;
                pulse_cnt++;
                snap     = cur_w;
                hold_bad = (pix_ready !== 1'b0);
                hold_ph  = 1;
            end
        end
    end

    initial begin
        // reset held with random pix_valid
        rstn = 1'b0;
        repeat (6) begin
            @(negedge clk);
            pix_valid = 1'($urandom_range(1));
            pix_data  = 9'($urandom);
            #1;
            chk("reset_outputs", 256'({pix_ready, x_valid, cur_w}), 256'({1'b1, 1'b0, 225'd0}));
        end
        @(negedge clk);
        pix_valid = 1'b0;
        rstn = 1'b1;

        // first frame, continuous
        pulse_cnt = 0;
        first_xv_cyc = -1;
        run_frame(0, 0, 0, 1'b1);
        idle(12);
        check_first_frame();

        // two back-to-back frames with bubbles
        pulse_cnt = 0;
        run_frame(0, 0, 30, 1'b0);
        run_frame(0, 100, 30, 1'b0);
        idle(12);
        chk("pulses_two_frames", 256'(pulse_cnt), 256'(32));
        chk("frame2_x_m_1", 256'(cap1[16]), 256'(pack5(100, 108, 116, 124, 132)));
        chk("frame2_x_m_5", 256'(cap5[16]), 256'(pack5(104, 112, 120, 128, 136)));

        // random frame with a -1 pixel at (4,4)
        pulse_cnt = 0;
        run_frame(1, 0, 20, 1'b0);
        idle(12);
        chk("sign_field", 256'(cap5[0][8:0]), 256'(9'h1FF));
        chk("pulses_random", 256'(pulse_cnt), 256'(16));

        // reset in the middle of a hold after beat 40
        pulse_cnt = 0;
        for (int k = 0; k < 40; k++) drive_pixel(9'(k), 0);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("pre_reset_hold", 256'(pix_ready), 256'(0));
        rstn = 1'b0;
        #1;
        chk("midop_reset_outputs", 256'({pix_ready, x_valid, cur_w}), 256'({1'b1, 1'b0, 225'd0}));
        exp_q.delete();
        mr = 0;
        mc = 0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        pulse_cnt = 0;
        first_xv_cyc = -1;
        run_frame(0, 0, 0, 1'b1);
        idle(12);
        check_first_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
